// File: rtl/npc_unit_pkg.sv
// npc_unit shared definitions.
// Control-flow opcodes and the default reset vector.
package npc_unit_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_op_e;

  localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] br_offset(
    input logic [15:0] imm16
  );
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_unit_target.sv
// npc_target: redirect target for the D-stage instruction.
// Pure combinational; SEQ yields the fall-through d_pc + 4.
module npc_target
  import npc_unit_pkg::*;
(
  input  logic [1:0]  npc_op,
  input  logic [31:0] d_pc,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_rs_val,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;

  assign pc_plus4 = d_pc + 32'd4;

  // Select the target by control-flow class.
  always_comb begin
    target = pc_plus4;
    unique case (npc_op)
      NPC_SEQ: target = pc_plus4;
      NPC_BR:  target = pc_plus4 + br_offset(d_imm16);
      NPC_J:   target = {d_pc[31:28], d_index26, 2'b00};
      NPC_JR:  target = d_rs_val;
      default: target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// npc_unit: fetch PC owner and control-flow resolver.
// Holds a taken redirect while imem is busy so it is never lost.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = NPC_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              imem_ready,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [1:0]        npc_op,
  input  logic              cmp_cond,
  input  logic [15:0]       d_imm16,
  input  logic [25:0]       d_index26,
  input  logic [ADDR_W-1:0] d_rs_val,
  output logic [ADDR_W-1:0] f_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] d_link,
  output logic              redirect_pending,
  output logic              f_adel
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_q, pend_d;
  logic [31:0] target;
  logic        redirect;

  npc_target u_target (
    .npc_op    (npc_op),
    .d_pc      (d_pc),
    .d_imm16   (d_imm16),
    .d_index26 (d_index26),
    .d_rs_val  (d_rs_val),
    .target    (target)
  );

  // A not-taken branch is not a redirect; bubbles never redirect.
  always_comb begin
    redirect = 1'b0;
    if (d_valid) begin
      unique case (npc_op)
        NPC_BR:  redirect = cmp_cond;
        NPC_J:   redirect = 1'b1;
        NPC_JR:  redirect = 1'b1;
        default: redirect = 1'b0;
      endcase
    end
  end

  // Next PC / pending state; stall dominates, a live redirect beats pending.
  always_comb begin
    f_pc_d     = f_pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_d     = pend_q;
    if (stall) begin
      f_pc_d = f_pc_q;
    end else if (imem_ready) begin
      if (redirect)
        f_pc_d = target;
      else if (pend_q)
        f_pc_d = pend_tgt_q;
      else
        f_pc_d = f_pc_q + 32'd4;
      pend_d = 1'b0;
    end else if (redirect) begin
      pend_tgt_d = target;
      pend_d     = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc_q     <= RESET_PC;
      pend_tgt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      f_pc_q     <= f_pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_q     <= pend_d;
    end
  end

  assign f_pc             = f_pc_q;
  assign imem_req         = ~reset;
  assign d_link           = d_pc + 32'd8;
  assign redirect_pending = pend_q;
  assign f_adel           = |f_pc_q[1:0];

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
Owns the fetch PC and resolves control flow for the 5-stage MIPS pipeline. It consumes the branch-condition bit produced by the D-stage comparator, together with the decoded control-flow opcode, and computes the next fetch address. Branches have a single delay slot. A taken redirect is held in a pending register when instruction memory is not ready, so the redirect is never lost.

Parameters:
RESET_PC, 32'h0000_3000, fetch address loaded on reset
ADDR_W, 32, PC width (fixed at 32 for this core)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
stall  input  1  D-stage hazard stall; freezes F and D
imem_ready  input  1  instruction memory returned the F-stage word this cycle
d_valid  input  1  D stage holds a real instruction (0 = bubble)
d_pc  input  32  PC of the D-stage instruction
npc_op  input  2  control-flow class of the D instruction: SEQ, BR, J, JR
cmp_cond  input  1  comparator output; 1 = branch condition true
d_imm16  input  16  branch offset field
d_index26  input  26  jump index field
d_rs_val  input  32  forwarded rs value, used as the jr target
f_pc  output  32  current fetch address
imem_req  output  1  fetch request; equals !reset
d_link  output  32  link address d_pc + 8 (jal/jalr)
redirect_pending  output  1  latched redirect not yet applied
f_adel  output  1  f_pc[1:0] != 0 (address-error-on-fetch flag)

Behaviour:
- Reset (synchronous, active-high): f_pc = RESET_PC, pending_target = 0, redirect_pending = 0. The derived outputs follow from these: f_adel = 0 and imem_req = 0 while reset is held.
- Target computation (combinational):
  - BR: d_pc + 4 + (sign-extended imm16 << 2), mod 2^32.
  - J: {d_pc[31:28], index26, 2'b00}. Bits [31:28] come from d_pc (d_pc + 4 is not used).
  - JR: d_rs_val unmodified. Misalignment is not masked.
- redirect = d_valid & ((npc_op==BR & cmp_cond) | npc_op==J | npc_op==JR). BR with cmp_cond=0 is not a redirect.
- Delay slot: the redirect takes effect on the fetch following the delay slot. When the branch is in D, F already holds d_pc+4, and that fetch completes normally.
- Per-cycle update, in priority order:
  1. stall=1: f_pc, pending_target and redirect_pending all hold. The D instruction is re-presented next cycle, so its redirect is recomputed and no latching is needed.
  2. stall=0, imem_ready=1: f_pc <= redirect ? target : redirect_pending ? pending_target : f_pc+4. Then redirect_pending <= 0.
  3. stall=0, imem_ready=0, redirect=1: pending_target <= target, redirect_pending <= 1, f_pc holds. D receives a bubble.
  4. stall=0, imem_ready=0, redirect=0: everything holds.
- Simultaneous redirect and redirect_pending: illegal in the pipeline, because D is a bubble while a redirect is pending. If it occurs anyway, the live redirect wins and the pending entry is discarded.
- f_pc+4 wraps from 32'hFFFF_FFFC to 0 with no flag.
- d_link = d_pc + 8 always, independent of npc_op.
- f_adel is combinational from f_pc. The unit keeps fetching; the exception path consumes the flag.
- Reset asserted mid-pending clears the pending entry. The first fetch after reset release is RESET_PC.

Decomposition:
- Defines.v gains NPC_SEQ=2'd0, NPC_BR=2'd1, NPC_J=2'd2, NPC_JR=2'd3 and the default reset vector.
- One combinational sub-module, npc_target, computes the target from npc_op, d_pc, d_imm16, d_index26 and d_rs_val.
- npc_unit holds the sequential state: the PC register, the pending register and the priority logic.

Test Plan:
- Reset then 3 cycles with imem_ready=1, no redirect -> f_pc = 0x3000, 0x3004, 0x3008, 0x300C. imem_req = 0 during reset.
- BR taken, d_pc=0x3004, imm16=0xFFFF, cmp_cond=1, imem_ready=1 -> next f_pc = 0x3004. BR not taken, cmp_cond=0 -> f_pc+4.
- J, d_pc=0x3010, index26=0x0000C40 -> next f_pc = 0x0000_3100. JR with d_rs_val=0x3202 -> f_pc = 0x3202 and f_adel = 1.
- Taken BR with imem_ready=0 for 2 cycles, target 0x3400 -> redirect_pending=1 and f_pc held. When imem_ready=1 (d_valid=0), f_pc = 0x3400 and pending clears.
- stall=1 for 3 cycles with a taken BR in D -> f_pc frozen and no pending latched. On the stall=0 cycle, f_pc = target.
- f_pc=0xFFFF_FFFC with sequential fetch -> wraps to 0x0000_0000. Reset during a pending redirect -> f_pc=0x3000 and redirect_pending=0.
